// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: bit positions inside the decoded control bundle.
package pipeline_pkg;

    localparam int unsigned CTRL_W_DEFAULT = 16;

    localparam int unsigned CTRL_REGWRITE  = 0;
    localparam int unsigned CTRL_MEMREAD   = 1;
    localparam int unsigned CTRL_MEMWRITE  = 2;
    localparam int unsigned CTRL_MEMTOREG  = 3;
    localparam int unsigned CTRL_ALUSRC    = 4;
    localparam int unsigned CTRL_BRANCH    = 5;
    localparam int unsigned CTRL_JUMP      = 6;
    localparam int unsigned CTRL_ALUOP_LSB = 7;
    localparam int unsigned CTRL_ALUOP_MSB = 11;
    localparam int unsigned CTRL_MULDIV    = 12;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in EX whose rd matches either source in ID.
module load_use_detect (
    input  logic       ex_valid_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    output logic       hazard_o
);

    logic rd_match;

    // Both sources compared even if the instruction ignores one; a spare stall is harmless.
    always_comb begin
        rd_match = (ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i);
        hazard_o = ex_valid_i && ex_memread_i && (ex_rd_i != 5'd0) && id_valid_i && rd_match;
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with flush, hold and load-use bubble insertion.
// Define ID_EX_LOAD_USE_DETECT_EN to enable internal load-use detection and bubble_cnt.
module id_ex_stage_reg
    import pipeline_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_DEFAULT,
    parameter int unsigned XLEN   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_flush,
    input  logic              ex_hold,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ID_EX_rs1,
    output logic [4:0]        ID_EX_rs2,
    output logic [4:0]        ID_EX_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              stall_if_id,
    output logic [15:0]       bubble_cnt
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [4:0]        rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              hazard;
    logic              lu_bubble;

`ifdef ID_EX_LOAD_USE_DETECT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    load_use_detect u_load_use_detect (
        .ex_valid_i   (valid_q),
        .ex_memread_i (ctrl_q[CTRL_MEMREAD]),
        .ex_rd_i      (rd_q),
        .id_valid_i   (id_valid),
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .hazard_o     (hazard)
    );

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (lu_bubble && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bubble_cnt_q <= 16'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    assign hazard     = 1'b0;
    assign bubble_cnt = 16'd0;
`endif

    // A load-use bubble is only taken when neither flush nor hold claims the edge.
    assign lu_bubble   = hazard & ~ex_flush & ~ex_hold;
    assign stall_if_id = (ex_hold & ~ex_flush) | lu_bubble;

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        ctrl_d     = ctrl_q;
        if (ex_flush || (!ex_hold && hazard)) begin
            // Bubble: data fields keep their old values.
            valid_d = 1'b0;
            ctrl_d  = '0;
            rd_d    = 5'd0;
            rs1_d   = 5'd0;
            rs2_d   = 5'd0;
        end else if (!ex_hold) begin
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            valid_d    = id_valid;
            // Invalid slots enter as bubbles so no downstream write-enable can fire.
            ctrl_d     = id_valid ? id_ctrl : '0;
            rd_d       = id_valid ? id_rd : 5'd0;
            rs1_d      = id_valid ? id_rs1 : 5'd0;
            rs2_d      = id_valid ? id_rs2 : 5'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            ctrl_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rs1_data = rs1_data_q;
    assign ex_rs2_data = rs2_data_q;
    assign ex_imm      = imm_q;
    assign ID_EX_rs1   = rs1_q;
    assign ID_EX_rs2   = rs2_q;
    assign ID_EX_rd    = rd_q;
    assign ex_ctrl     = ctrl_q;

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register for the RV32IM five-stage pipeline, with integrated load-use hazard detection. It captures decoded operands and control from ID, and presents `ID_EX_rs1`, `ID_EX_rs2`, `ID_EX_rd` and control bits to the EX stage and the forwarding logic. It inserts a one-cycle bubble on a load-use dependency, holds during multi-cycle M-extension operations, and squashes on a taken branch or jump.

## Interface
- `CTRL_W`, 16: width of the decoded control bundle; bit positions come from the shared package.
- `XLEN`, 32: datapath width.

Ports:
- `clk`  in  1  pipeline clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_pc`  in  XLEN  PC of the ID instruction.
- `id_rs1_data`, `id_rs2_data`  in  XLEN  register-file read data.
- `id_imm`  in  XLEN  sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd`  in  5  register indices.
- `id_ctrl`  in  CTRL_W  decoded control bundle.
- `ex_flush`  in  1  taken branch or jump resolved in EX; squash the ID instruction.
- `ex_hold`  in  1  EX busy with a multi-cycle MUL/DIV; freeze.
- `ex_valid`  out  1  EX holds a real instruction.
- `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm`  out  XLEN  registered copies.
- `ID_EX_rs1`, `ID_EX_rs2`, `ID_EX_rd`  out  5  registered indices.
- `ex_ctrl`  out  CTRL_W  registered control.
- `stall_if_id`  out  1  freeze the PC and the IF/ID register this cycle.
- `bubble_cnt`  out  16  saturating count of inserted load-use bubbles.

## Operation
- Each rising `clk` performs exactly one of the following actions, in priority order:
  1. `ex_flush`: load a bubble.
  2. `ex_hold`: keep all registers unchanged.
  3. Load-use hazard: load a bubble.
  4. Otherwise: load all `id_*` fields. `ex_valid` is loaded from `id_valid`.
- Bubble: `ex_valid`=0, `ex_ctrl`=0, `ID_EX_rd`=0, `ID_EX_rs1`=0, `ID_EX_rs2`=0. The data fields are don't-care and are held at their previous values.
- Load-use hazard is combinational. It requires all of the following:
  - `ex_valid`=1.
  - `ex_ctrl[CTRL_MEMREAD]`=1.
  - `ID_EX_rd`≠0.
  - `id_valid`=1.
  - `ID_EX_rd` equals `id_rs1` or `id_rs2`. The comparison is conservative: both indices are checked regardless of whether the instruction uses them.
- `stall_if_id` = (`ex_hold` & ~`ex_flush`) | (hazard & ~`ex_flush` & ~`ex_hold`).
  - During a flush, `stall_if_id`=0; upstream flushes IF/ID itself.
- The bubble after a load-use stall clears the hazard by construction. The stalled instruction therefore enters EX on the following edge, giving exactly one bubble per dependent load.
- An instruction with `id_valid`=0 is loaded as a bubble (ctrl and rd zeroed) so that downstream write-enables are never set.
- `bubble_cnt` increments on each load-use bubble edge and saturates at 16'hFFFF. It does not count flushes or holds.

## Timing
- Register latency is 1 cycle from the `id_*` inputs to the `ex_*` and `ID_EX_*` outputs.
- `stall_if_id` has 0-cycle latency and is combinational from inputs and registered state. It has no path from itself.
- Reset (`reset_n`=0, asynchronous) sets every registered output to 0, including `ex_valid`, `ex_ctrl` and `bubble_cnt`. `stall_if_id` then evaluates to `ex_hold` & ~`ex_flush`.
- Reset asserted mid-hold or mid-stall aborts immediately. The first edge after release loads from ID normally.
- Simultaneous events:
  - Flush + hold: flush wins.
  - Flush + hazard: bubble, no stall.
  - Hold + hazard: hold, with `stall_if_id`=1. The hazard is re-evaluated after the hold releases.
- `ex_hold` held for N cycles keeps the outputs bit-stable for N edges.

## Configuration
- `ID_EX_LOAD_USE_DETECT_EN` defined: hazard detection and `bubble_cnt` are active as described above.
- Not defined: the hazard term is tied to 0 and `bubble_cnt` is tied to 0. `stall_if_id` = `ex_hold` & ~`ex_flush`. Load-use stalls are then the responsibility of an external unit, which drives `ex_hold`.

## Structure
- Shared package `pipeline_pkg`, containing:
  - Constants `CTRL_REGWRITE`=0, `CTRL_MEMREAD`=1, `CTRL_MEMWRITE`=2, `CTRL_MEMTOREG`=3, `CTRL_ALUSRC`=4, `CTRL_BRANCH`=5, `CTRL_JUMP`=6, `CTRL_ALUOP` [11:7], `CTRL_MULDIV`=12.
  - The `CTRL_W` default.
- One sub-module, `load_use_detect`: a purely combinational hazard comparator, instantiated only under the macro.

## Test plan
- Load followed by dependent ALU op:
  - Stimulus: EX holds `lw x5` (`ex_valid`=1, MEMREAD=1, `ID_EX_rd`=5); ID presents `add x6,x5,x7`.
  - Required: `stall_if_id`=1 for one cycle; the next edge loads a bubble (`ex_valid`=0, `ID_EX_rd`=0); the edge after that loads `add` with `ID_EX_rs1`=5. `bubble_cnt`=1.
- Load to x0:
  - Stimulus: `lw x0` followed by `add x1,x0,x0`.
  - Required: no stall; `add` loads on the next edge.
- Flush during a hazard:
  - Stimulus: `ex_flush`=1 while the load-use condition is true.
  - Required: `stall_if_id`=0; bubble loaded; `bubble_cnt` unchanged.
- Hold for 3 cycles:
  - Stimulus: `ex_hold`=1 for 3 cycles while ID changes every cycle.
  - Required: outputs stay equal to the pre-hold values; `stall_if_id`=1 throughout; ID loads on the first edge after release.
- Reset mid-hold:
  - Stimulus: `reset_n` driven to 0 asynchronously between edges during a hold.
  - Required: all registered outputs go to 0 immediately.
- Macro undefined, load-use stimulus:
  - Required: no stall; the dependent instruction loads directly; `bubble_cnt`=0.
